// File: rtl/pc_gen_if.sv
// Fetch-side handshake between the PC generator and instruction fetch.
// The generator presents pc/pc_plus/pc_valid and fetch answers with if_ready.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic              pc_valid;
    logic              if_ready;

    modport master (
        output pc,
        output pc_plus,
        output pc_valid,
        input  if_ready
    );

    modport slave (
        input  pc,
        input  pc_plus,
        input  pc_valid,
        output if_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with prioritised redirects, a latched
// pending branch for the delay-slot case, and misaligned-fetch (AdEL) flagging.
module pc_gen #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'hBFC0_0000),
    parameter logic [ADDR_W-1:0] EXC_VEC     = ADDR_W'(32'hBFC0_0380),
    parameter int unsigned       INC         = 4,
    parameter bit                ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic              adel,
    output logic              br_pending,
    pc_gen_if.master          fetch
);

    localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

    typedef enum logic {
        RST_HOLD = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              br_pending_q, br_pending_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic [ADDR_W-1:0] pc_plus;
    logic              accept;

    assign pc_plus = pc_q + INC_W;
    assign accept  = pc_valid_q & fetch.if_ready & ~stall;

    // Exception and ERET redirect even without accept, killing the in-flight fetch;
    // a branch seen without accept waits until the delay-slot fetch is taken.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_valid_d    = pc_valid_q;
        br_pending_d  = br_pending_q;
        pend_target_d = pend_target_q;
        case (state_q)
            RST_HOLD: begin
                state_d    = RUN;
                pc_valid_d = 1'b1;
            end
            RUN: begin
                if (exc_req) begin
                    pc_d          = EXC_VEC;
                    br_pending_d  = 1'b0;
                    pend_target_d = '0;
                end else if (eret_req) begin
                    pc_d          = epc;
                    br_pending_d  = 1'b0;
                    pend_target_d = '0;
                end else if (accept && br_taken) begin
                    pc_d          = br_target;
                    br_pending_d  = 1'b0;
                    pend_target_d = '0;
                end else if (accept && br_pending_q) begin
                    pc_d          = pend_target_q;
                    br_pending_d  = 1'b0;
                    pend_target_d = '0;
                end else if (accept) begin
                    pc_d = pc_plus;
                end else if (br_taken) begin
                    br_pending_d  = 1'b1;
                    pend_target_d = br_target;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RST_HOLD;
            pc_q          <= RESET_VEC;
            pc_valid_q    <= 1'b0;
            br_pending_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            br_pending_q  <= br_pending_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign fetch.pc       = pc_q;
    assign fetch.pc_plus  = pc_plus;
    assign fetch.pc_valid = pc_valid_q;
    assign br_pending     = br_pending_q;
    assign adel           = ALIGN_CHECK & pc_valid_q & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a redirect-priority model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_pc_gen;

    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        adel;
    logic        br_pending;

    int vectors     = 0;
    int miscompares = 0;

    pc_gen_if #(.ADDR_W(32)) fetch_if ();

    pc_gen #(
        .ADDR_W(32),
        .RESET_VEC(RESET_VEC),
        .EXC_VEC(EXC_VEC),
        .INC(4),
        .ALIGN_CHECK(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .exc_req(exc_req),
        .eret_req(eret_req),
        .epc(epc),
        .adel(adel),
        .br_pending(br_pending),
        .fetch(fetch_if)
    );

    always #5 clk = ~clk;

    // Reference model: fetch address, live flag, and a waiting branch target.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] m_tgt;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc    = RESET_VEC;
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_tgt   = 32'h0;
            m_live  = 1'b1;
        end else if (m_live) begin
            if (!m_valid) begin
                m_valid = 1'b1;
            end else begin
                automatic bit taken = fetch_if.if_ready && !stall;
                if (exc_req) begin
                    m_pc = EXC_VEC; m_pend = 1'b0;
                end else if (eret_req) begin
                    m_pc = epc; m_pend = 1'b0;
                end else if (taken && br_taken) begin
                    m_pc = br_target; m_pend = 1'b0;
                end else if (taken && m_pend) begin
                    m_pc = m_tgt; m_pend = 1'b0;
                end else if (taken) begin
                    m_pc = m_pc + 32'd4;
                end else if (br_taken) begin
                    m_tgt = br_target; m_pend = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("model.pc",         fetch_if.pc,             m_pc);
            checkOutput("model.pc_valid",   32'(fetch_if.pc_valid),  32'(m_valid));
            checkOutput("model.br_pending", 32'(br_pending),         32'(m_pend));
            checkOutput("model.pc_plus",    fetch_if.pc_plus,        m_pc + 32'd4);
            checkOutput("model.adel",       32'(adel),
                        32'(m_valid && (m_pc[1:0] != 2'b00)));
        end
    end

    task automatic applyStimulus(input logic r, input logic st, input logic rdy,
                                 input logic br, input logic [31:0] tgt,
                                 input logic exc, input logic eret, input logic [31:0] e);
        rst              = r;
        stall            = st;
        fetch_if.if_ready = rdy;
        br_taken         = br;
        br_target        = tgt;
        exc_req          = exc;
        eret_req         = eret;
        epc              = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expectPc(input string name, input logic [31:0] pc_exp,
                            input logic valid_exp, input logic pend_exp);
        checkOutput({name, ".pc"},         fetch_if.pc,            pc_exp);
        checkOutput({name, ".pc_valid"},   32'(fetch_if.pc_valid), 32'(valid_exp));
        checkOutput({name, ".br_pending"}, 32'(br_pending),        32'(pend_exp));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; fetch_if.if_ready = 1'b1;
        br_taken = 1'b0; br_target = '0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;

        // Reset release: one dead cycle, then sequential fetch from the reset vector.
        repeat (3) applyStimulus(1, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("reset", 32'hBFC0_0000, 0, 0);
        rst = 1'b0;
        #1;
        expectPc("release_gap", 32'hBFC0_0000, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("first_fetch", 32'hBFC0_0000, 1, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("seq1", 32'hBFC0_0004, 1, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("seq2", 32'hBFC0_0008, 1, 0);

        // Stall holds the fetch address with pc_valid still high.
        repeat (3) begin
            applyStimulus(0, 1, 1, 0, 32'h0, 0, 0, 32'h0);
            expectPc("stall_hold", 32'hBFC0_0008, 1, 0);
        end
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("stall_release", 32'hBFC0_000C, 1, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("seq3", 32'hBFC0_0010, 1, 0);

        // Branch without accept is latched and applied on the next accepted fetch.
        applyStimulus(0, 0, 0, 1, 32'h8000_1000, 0, 0, 32'h0);
        expectPc("pend_latch", 32'hBFC0_0010, 1, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        expectPc("pend_wait", 32'hBFC0_0010, 1, 1);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("pend_apply", 32'h8000_1000, 1, 0);

        // Latest pending branch wins; exception beats ERET and branch.
        applyStimulus(0, 0, 0, 1, 32'h8000_2000, 0, 0, 32'h0);
        expectPc("pend_again", 32'h8000_1000, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h8000_2800, 0, 0, 32'h0);
        expectPc("pend_overwrite", 32'h8000_1000, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h8000_3000, 1, 1, 32'h8000_0200);
        expectPc("exc_priority", 32'hBFC0_0380, 1, 0);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 1, 32'h8000_0200);
        expectPc("eret", 32'h8000_0200, 1, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("after_eret", 32'h8000_0204, 1, 0);

        // Address wrap and misaligned-fetch flag.
        applyStimulus(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        expectPc("wrap_top", 32'hFFFF_FFFC, 1, 0);
        checkOutput("wrap_top.pc_plus", fetch_if.pc_plus, 32'h0000_0000);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("wrap_zero", 32'h0000_0000, 1, 0);
        checkOutput("wrap_zero.adel", 32'(adel), 32'd0);
        applyStimulus(0, 0, 1, 1, 32'h8000_0002, 0, 0, 32'h0);
        expectPc("misalign", 32'h8000_0002, 1, 0);
        checkOutput("misalign.adel", 32'(adel), 32'd1);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("misalign_seq.pc", fetch_if.pc, 32'h8000_0006);
        checkOutput("misalign_seq.adel", 32'(adel), 32'd1);
        applyStimulus(0, 0, 1, 1, 32'h8000_0010, 0, 0, 32'h0);
        checkOutput("realign.adel", 32'(adel), 32'd0);

        // Reset mid-operation drops the pending branch.
        applyStimulus(0, 0, 0, 1, 32'h8000_4000, 0, 0, 32'h0);
        expectPc("pend_before_rst", 32'h8000_0010, 1, 1);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        expectPc("mid_reset", 32'hBFC0_0000, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("mid_reset_run", 32'hBFC0_0000, 1, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        expectPc("mid_reset_seq", 32'hBFC0_0004, 1, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage, replacing the simple PC register. It holds the fetch address and drives a valid/ready handshake to instruction fetch. Redirects are applied by priority: exception, then ERET, then branch, then sequential. A branch that arrives while the delay-slot fetch is still outstanding is latched as pending and applied on the next accepted fetch. The block also flags misaligned fetch addresses (AdEL) for the exception unit.

Parameters:
ADDR_W, 32, PC width in bits; all address arithmetic is modulo 2^ADDR_W.
RESET_VEC, 32'hBFC00000, PC value loaded by reset (ADDR_W bits).
EXC_VEC, 32'hBFC00380, PC loaded when exc_req is taken.
INC, 4, sequential increment in bytes.
ALIGN_CHECK, 1, 1 = drive adel on misaligned pc; 0 = adel tied to 0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  1  pipeline hold; blocks fetch acceptance.
if_ready  in  1  fetch unit can accept pc this cycle.
br_taken  in  1  branch/jump resolved taken (one-cycle pulse).
br_target  in  ADDR_W  branch/jump destination.
exc_req  in  1  exception redirect request.
eret_req  in  1  return-from-exception request.
epc  in  ADDR_W  ERET destination.
pc  out  ADDR_W  current fetch address (registered).
pc_valid  out  1  pc is a live fetch request (registered).
pc_plus  out  ADDR_W  pc + INC (combinational from pc).
adel  out  1  pc_valid & ALIGN_CHECK & (pc[1:0] != 0).
br_pending  out  1  a latched branch target is waiting (registered).

Behaviour:
- Handshake: accept = pc_valid & if_ready & ~stall. pc only advances on accept; otherwise it holds, including under stall.
- States:
  - RST_HOLD: entered while rst=1. pc = RESET_VEC, pc_valid = 0, br_pending = 0, pend_target = 0. The next cycle goes to RUN unconditionally.
  - RUN: pc_valid = 1.
  - pc_valid is 0 for exactly one cycle after rst deasserts; the first fetch of RESET_VEC is presented on cycle 2.
- Next-pc priority, evaluated each RUN cycle:
  1. exc_req: pc <= EXC_VEC; pending cleared. Applies regardless of accept or stall, killing the current fetch.
  2. eret_req (no exc_req): pc <= epc; pending cleared. Applies regardless of accept or stall.
  3. accept & br_taken: pc <= br_target; pending cleared.
  4. accept & br_pending: pc <= pend_target; pending cleared.
  5. accept: pc <= pc + INC, dropping the carry (wraps at 2^ADDR_W).
  6. ~accept & br_taken: pend_target <= br_target, br_pending <= 1, pc holds. The delay-slot fetch must complete first.
  7. Otherwise: hold.
- Simultaneous events:
  - exc_req and eret_req together: exc wins.
  - br_taken while br_pending=1: the new target overwrites pend_target (latest wins).
  - br_taken with exc_req or eret_req: the branch is discarded.
- adel is combinational from registered state. adel does not block pc_valid; the exception unit responds with exc_req.
- Reset mid-operation (rst=1 in any cycle): the next edge restores the RST_HOLD values; pending branch and in-flight redirects are lost.
- No combinational path from inputs to pc, pc_valid or br_pending. pc_plus and adel depend only on registers.

Test Plan:
1. Reset release: rst=1 for 3 cycles, then 0, with if_ready=1 -> pc_valid 0 for one cycle after release; then pc = BFC00000, BFC00004, BFC00008 on successive cycles.
2. Stall: at pc=BFC00008, stall=1 for 3 cycles -> pc holds BFC00008 and pc_valid stays 1; after stall drops, pc = BFC0000C next cycle.
3. Pending branch: at pc=BFC00010, if_ready=0, pulse br_taken with br_target=80001000 -> br_pending=1 and pc holds. Then raise if_ready -> pc = 80001000 and br_pending=0.
4. Priority: in the same cycle drive exc_req=1, eret_req=1 (epc=80000200), br_taken=1, with br_pending=1 -> pc = BFC00380 and br_pending=0. Next cycle, eret_req alone -> pc = 80000200.
5. Wrap and alignment: br_target=FFFFFFFC taken with accept -> pc = FFFFFFFC, then 00000000. Separately, br_target=80000002 -> adel=1 while pc=80000002.
6. Mid-operation reset: with br_pending=1 and stall=1, assert rst one cycle -> pc = BFC00000, pc_valid=0, br_pending=0 the following cycle.
